// File: rtl/oled_spi_receiver_if.sv
// ============================================================================
//  Module      : oled_spi_receiver_if
//  Description : Bundle of the OLED SPI pins, the FIFO output handshake and
//                the sticky status flags of oled_spi_receiver.
//                slave  : receiver view (SPI pins in, FIFO head/status out)
//                master : transmitter/consumer view (the mirror image)
//  Ports       : i_CS, i_SCK, i_MOSI, i_DC, i_RES  - OLED SPI pins
//                i_CLR                             - clear sticky flags
//                i_READY / o_VALID / o_DATA / o_DC - FIFO head handshake
//                o_COUNT                           - FIFO occupancy
//                o_OVERFLOW / o_FRAME_ERR          - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface oled_spi_receiver_if #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                        i_CS;
  logic                        i_SCK;
  logic                        i_MOSI;
  logic                        i_DC;
  logic                        i_RES;
  logic                        i_CLR;
  logic                        i_READY;
  logic [WIDTH-1:0]            o_DATA;
  logic                        o_DC;
  logic                        o_VALID;
  logic [$clog2(FIFO_DEPTH):0] o_COUNT;
  logic                        o_OVERFLOW;
  logic                        o_FRAME_ERR;

  modport slave (
    input  i_CS, i_SCK, i_MOSI, i_DC, i_RES, i_CLR, i_READY,
    output o_DATA, o_DC, o_VALID, o_COUNT, o_OVERFLOW, o_FRAME_ERR
  );

  modport master (
    output i_CS, i_SCK, i_MOSI, i_DC, i_RES, i_CLR, i_READY,
    input  o_DATA, o_DC, o_VALID, o_COUNT, o_OVERFLOW, o_FRAME_ERR
  );
endinterface

`default_nettype wire

// File: rtl/oled_spi_receiver.sv
// ============================================================================
//  Module      : oled_spi_receiver
//  Description : Oversampling SPI slave for the OLED PMOD stream. Rebuilds
//                MSB-first bytes, tags each with DC and queues it in a FIFO.
//  Ports       : i_CLK   - system clock (SCK is only sampled, never a clock)
//                i_RST_N - asynchronous active-low reset
//                bus     - oled_spi_receiver_if.slave (SPI pins, FIFO head
//                          handshake, occupancy and sticky error flags)
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module oled_spi_receiver #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  wire logic            i_CLK,
  input  wire logic            i_RST_N,
  oled_spi_receiver_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WIDTH);

  // Pin vector layout {cs, sck, res, mosi, dc} and its idle level
  localparam int P_CS   = 4;
  localparam int P_SCK  = 3;
  localparam int P_RES  = 2;
  localparam int P_MOSI = 1;
  localparam int P_DC   = 0;
  localparam logic [4:0] PIN_IDLE = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_RESET_HOLD = 2'd2
  } state_t;

  // Input conditioning
  logic [4:0]       sync_q [SYNC_STAGES];
  logic [4:0]       sync_d [SYNC_STAGES];
  logic [4:0]       pins_s;
  logic             sck_prev_q, sck_prev_d;
  logic             sck_rise_q, sck_rise_d;
  logic             cs_q, cs_d;
  logic             res_q, res_d;
  logic             mosi_q, mosi_d;
  logic             dc_q, dc_d;

  // Receive FSM
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] byte_full;
  logic             push;
  logic             frame_set;

  // FIFO and flags
  logic [WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [WIDTH:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             pop, full, do_push, ovf_set;

  // Sampled pins are registered once more alongside the SCK edge pulse so
  // that MOSI/DC/CS/RES are all seen in the same cycle as the edge.
  always_comb begin
    sync_d[0] = {bus.i_CS, bus.i_SCK, bus.i_RES, bus.i_MOSI, bus.i_DC};
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    pins_s     = sync_q[SYNC_STAGES-1];
    sck_prev_d = pins_s[P_SCK];
    sck_rise_d = pins_s[P_SCK] & ~sck_prev_q;
    cs_d       = pins_s[P_CS];
    res_d      = pins_s[P_RES];
    mosi_d     = pins_s[P_MOSI];
    dc_d       = pins_s[P_DC];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    byte_full = {shift_q, mosi_q};
    if (!res_q) begin
      // RES low overrides everything; a partial byte is a framing error.
      state_d   = ST_RESET_HOLD;
      cnt_d     = '0;
      frame_set = (cnt_q != '0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!cs_q) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_q) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            frame_set = (cnt_q != '0);
          end else if (sck_rise_q) begin
            shift_d = byte_full[WIDTH-2:0];
            if (cnt_q == CW'(WIDTH-1)) begin
              push  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_RESET_HOLD: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FIFO: a pop needs a non-empty FIFO, so push+pop on empty is push only.
  always_comb begin
    pop     = (count_q != '0) && bus.i_READY;
    full    = (count_q == (AW+1)'(FIFO_DEPTH));
    do_push = push && (!full || pop);
    ovf_set = push && full && !pop;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_q] = {dc_q, byte_full};
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({do_push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // Set has priority over a coincident clear.
    ovf_d  = ovf_set   ? 1'b1 : (bus.i_CLR ? 1'b0 : ovf_q);
    ferr_d = frame_set ? 1'b1 : (bus.i_CLR ? 1'b0 : ferr_q);
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= PIN_IDLE;
      sck_prev_q <= 1'b1;
      sck_rise_q <= 1'b0;
      cs_q       <= 1'b1;
      res_q      <= 1'b1;
      mosi_q     <= 1'b0;
      dc_q       <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      sck_prev_q <= sck_prev_d;
      sck_rise_q <= sck_rise_d;
      cs_q       <= cs_d;
      res_q      <= res_d;
      mosi_q     <= mosi_d;
      dc_q       <= dc_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.o_DATA      = mem_q[rd_q][WIDTH-1:0];
  assign bus.o_DC        = mem_q[rd_q][WIDTH];
  assign bus.o_VALID     = (count_q != '0);
  assign bus.o_COUNT     = count_q;
  assign bus.o_OVERFLOW  = ovf_q;
  assign bus.o_FRAME_ERR = ferr_q;

endmodule

`default_nettype wire
